// File: rtl/sysreg_wrctl_if.sv
// Bus-side handshake between the DMD bus and the system register write/read sequencer.
//   REQ/RDWR/ADDR/DMDI : single-cycle access request (write when RDWR=1)
//   ERRCLR             : clears sticky ERR/OVR
//   DMDO               : held read data
//   GNT                : one-cycle access-complete pulse
//   BUSY               : sequencer not idle
//   ERR/OVR            : sticky out-of-window / dropped-request flags
interface sysreg_wrctl_if;
  logic        REQ;
  logic        RDWR;
  logic [13:0] ADDR;
  logic [15:0] DMDI;
  logic        ERRCLR;
  logic [15:0] DMDO;
  logic        GNT;
  logic        BUSY;
  logic        ERR;
  logic        OVR;

  modport master (
    output REQ, RDWR, ADDR, DMDI, ERRCLR,
    input  DMDO, GNT, BUSY, ERR, OVR
  );

  modport slave (
    input  REQ, RDWR, ADDR, DMDI, ERRCLR,
    output DMDO, GNT, BUSY, ERR, OVR
  );
endinterface

// File: rtl/sysreg_wrctl.sv
// Write/read sequencer in front of the gated system register bank.
// Decodes a 14-bit bus address against the window BASE..BASE+NREG-1 and either pulses the
// addressed slot's write strobes for one cycle or returns that slot's contents on DMDO.
//   CK, RST : clock, synchronous active-high reset
//   bus     : DMD bus request/response (sysreg_wrctl_if.slave)
//   RDATA   : concatenated slot outputs, slot k at [16k+15:16k]
//   CKenb   : per-slot clock gate enable, active-low
//   WBen    : per-slot write-back enable
//   DI      : held write data shared by all slots
module sysreg_wrctl #(
  parameter int unsigned NREG = 8,
  parameter logic [13:0] BASE = 14'h3FE0
) (
  input  logic                 CK,
  input  logic                 RST,
  sysreg_wrctl_if.slave        bus,
  input  logic [16*NREG-1:0]   RDATA,
  output logic [NREG-1:0]      CKenb,
  output logic [NREG-1:0]      WBen,
  output logic [15:0]          DI
);

  typedef enum logic [2:0] {StIdle, StDec, StWr, StRd, StDone} state_e;

  state_e          r_state;
  logic [13:0]     r_addr;
  logic            r_rdwr;
  logic [15:0]     r_dmdi;
  logic [3:0]      r_idx;
  logic [NREG-1:0] r_ckenb;
  logic [NREG-1:0] r_wben;
  logic [15:0]     r_di;
  logic [15:0]     r_dmdo;
  logic            r_gnt;
  logic            r_busy;
  logic            r_err;
  logic            r_ovr;

  logic [13:0]     w_idx;
  logic            w_valid;
  logic [NREG-1:0] w_sel;
  logic [15:0]     w_rdata;
  logic            w_err_set;
  logic            w_ovr_set;

  // Unsigned subtraction: addresses below BASE wrap to large values, but are also rejected
  // explicitly so a window near the top of the space cannot alias low addresses.
  assign w_idx   = r_addr - BASE;
  assign w_valid = (r_addr >= BASE) && (w_idx < 14'(NREG));

  always_comb begin
    w_sel = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      if (w_idx == 14'(k)) w_sel[k] = 1'b1;
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      if (r_idx == 4'(k)) w_rdata = RDATA[16*k +: 16];
    end
  end

  assign w_err_set = (r_state == StDec) && !w_valid;
  assign w_ovr_set = (r_state != StIdle) && bus.REQ;

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_rdwr  <= 1'b0;
      r_dmdi  <= '0;
      r_idx   <= '0;
      r_ckenb <= '1;
      r_wben  <= '0;
      r_di    <= '0;
      r_dmdo  <= '0;
      r_gnt   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      // Strobes default to inactive so every pulse lasts exactly one cycle.
      r_gnt   <= 1'b0;
      r_ckenb <= '1;
      r_wben  <= '0;
      // Set wins over a simultaneous clear.
      r_err   <= w_err_set | (r_err & ~bus.ERRCLR);
      r_ovr   <= w_ovr_set | (r_ovr & ~bus.ERRCLR);

      unique case (r_state)
        StIdle: begin
          if (bus.REQ) begin
            r_addr  <= bus.ADDR;
            r_rdwr  <= bus.RDWR;
            r_dmdi  <= bus.DMDI;
            r_busy  <= 1'b1;
            r_state <= StDec;
          end
        end
        StDec: begin
          r_idx <= w_idx[3:0];
          if (!w_valid) begin
            r_gnt   <= 1'b1;
            r_state <= StDone;
          end else if (r_rdwr) begin
            r_di    <= r_dmdi;
            r_ckenb <= ~w_sel;
            r_wben  <= w_sel;
            r_state <= StWr;
          end else begin
            r_state <= StRd;
          end
        end
        StWr: begin
          r_gnt   <= 1'b1;
          r_state <= StDone;
        end
        StRd: begin
          r_dmdo  <= w_rdata;
          r_gnt   <= 1'b1;
          r_state <= StDone;
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign CKenb    = r_ckenb;
  assign WBen     = r_wben;
  assign DI       = r_di;
  assign bus.DMDO = r_dmdo;
  assign bus.GNT  = r_gnt;
  assign bus.BUSY = r_busy;
  assign bus.ERR  = r_err;
  assign bus.OVR  = r_ovr;

endmodule

// File: tb/tb_sysreg_wrctl.sv
// Scoreboard bench for sysreg_wrctl: the stimulus queues the expected response of each
// accepted access, and a negedge monitor checks it when GNT appears.
module tb_sysreg_wrctl;
  localparam int unsigned NREG = 8;

  logic                CK = 1'b0;
  logic                RST = 1'b1;
  logic [16*NREG-1:0]  RDATA;
  logic [NREG-1:0]     CKenb;
  logic [NREG-1:0]     WBen;
  logic [15:0]         DI;

  sysreg_wrctl_if bus ();

  sysreg_wrctl #(
    .NREG (NREG),
    .BASE (14'h3FE0)
  ) dut (
    .CK    (CK),
    .RST   (RST),
    .bus   (bus),
    .RDATA (RDATA),
    .CKenb (CKenb),
    .WBen  (WBen),
    .DI    (DI)
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  typedef struct {
    int          issue;
    int          lat;
    logic [15:0] dmdo;
    logic [15:0] di;
    logic        err;
    logic [7:0]  wben;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: tracks strobe pulses and busy cycles, checks each grant against the scoreboard.
  logic [7:0] acc_wben = '0;
  int         pulses = 0;
  int         busy_cnt = 0;

  always @(negedge CK) begin
    if (RST) begin
      acc_wben = '0;
      pulses   = 0;
      busy_cnt = 0;
    end else begin
      logic [7:0] inv_w;
      exp_t       e;
      inv_w = ~WBen;
      check("ckenb_vs_wben", {24'h0, CKenb}, {24'h0, inv_w});
      if (WBen !== '0) begin
        acc_wben = acc_wben | WBen;
        pulses++;
      end
      if (bus.BUSY === 1'b1) busy_cnt++;
      if (bus.GNT === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_gnt: got GNT=1 at cycle %0d, expected no grant", cyc);
        end else begin
          e = sb.pop_front();
          check("latency",   cyc - e.issue, e.lat);
          check("busy_len",  busy_cnt, e.lat);
          check("dmdo",      {16'h0, bus.DMDO}, {16'h0, e.dmdo});
          check("di",        {16'h0, DI}, {16'h0, e.di});
          check("err",       {31'h0, bus.ERR}, {31'h0, e.err});
          check("wben_slot", {24'h0, acc_wben}, {24'h0, e.wben});
          check("wben_len",  pulses, (e.wben != 8'h00) ? 1 : 0);
        end
        acc_wben = '0;
        pulses   = 0;
        busy_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic drive_req(input logic rdwr, input logic [13:0] addr, input logic [15:0] data);
    bus.REQ  = 1'b1;
    bus.RDWR = rdwr;
    bus.ADDR = addr;
    bus.DMDI = data;
  endtask

  task automatic push(input int lat, input logic [15:0] dmdo, input logic [15:0] di,
                      input logic err, input logic [7:0] wben);
    exp_t e;
    e.issue = cyc;
    e.lat   = lat;
    e.dmdo  = dmdo;
    e.di    = di;
    e.err   = err;
    e.wben  = wben;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge CK);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d grants outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic access(input logic rdwr, input logic [13:0] addr, input logic [15:0] data,
                        input int lat, input logic [15:0] dmdo, input logic [15:0] di,
                        input logic err, input logic [7:0] wben);
    step();
    drive_req(rdwr, addr, data);
    push(lat, dmdo, di, err, wben);
    step();
    bus.REQ = 1'b0;
    drain(20);
  endtask

  task automatic clear_flags();
    step();
    bus.ERRCLR = 1'b1;
    step();
    bus.ERRCLR = 1'b0;
  endtask

  initial begin
    bus.REQ    = 1'b0;
    bus.RDWR   = 1'b0;
    bus.ADDR   = '0;
    bus.DMDI   = '0;
    bus.ERRCLR = 1'b0;
    for (int k = 0; k < NREG; k++) RDATA[16*k +: 16] = 16'hC000 + 16'(k);
    RDATA[16*5 +: 16] = 16'h1234;

    // Reset for two edges.
    repeat (2) @(posedge CK);
    #1;
    RST = 1'b0;
    @(negedge CK);
    check("rst_ckenb", {24'h0, CKenb}, 32'hFF);
    check("rst_wben",  {24'h0, WBen}, 32'h00);
    check("rst_di",    {16'h0, DI}, 32'h0);
    check("rst_dmdo",  {16'h0, bus.DMDO}, 32'h0);
    check("rst_gnt",   {31'h0, bus.GNT}, 32'h0);
    check("rst_busy",  {31'h0, bus.BUSY}, 32'h0);
    check("rst_err",   {31'h0, bus.ERR}, 32'h0);
    check("rst_ovr",   {31'h0, bus.OVR}, 32'h0);

    // Writes and reads, including both ends of the window.
    access(1'b1, 14'h3FE3, 16'hA5C3, 3, 16'h0000, 16'hA5C3, 1'b0, 8'h08);
    access(1'b0, 14'h3FE5, 16'h0000, 3, 16'h1234, 16'hA5C3, 1'b0, 8'h00);
    access(1'b1, 14'h3FE7, 16'h5A5A, 3, 16'h1234, 16'h5A5A, 1'b0, 8'h80);
    access(1'b1, 14'h3FE0, 16'h0F0F, 3, 16'h1234, 16'h0F0F, 1'b0, 8'h01);
    access(1'b0, 14'h3FE0, 16'h0000, 3, 16'hC000, 16'h0F0F, 1'b0, 8'h00);

    // Out-of-window: just above the window, far below it, one below BASE.
    access(1'b0, 14'h3FE8, 16'h0000, 2, 16'hC000, 16'h0F0F, 1'b1, 8'h00);
    clear_flags();
    check("errclr_1", {31'h0, bus.ERR}, 32'h0);
    access(1'b1, 14'h0010, 16'hBEEF, 2, 16'hC000, 16'h0F0F, 1'b1, 8'h00);
    clear_flags();
    check("errclr_2", {31'h0, bus.ERR}, 32'h0);

    // ERRCLR during the DEC cycle of a new error: the set wins.
    step();
    drive_req(1'b0, 14'h3FDF, 16'h0000);
    push(2, 16'hC000, 16'h0F0F, 1'b1, 8'h00);
    step();
    bus.REQ    = 1'b0;
    bus.ERRCLR = 1'b1;
    step();
    bus.ERRCLR = 1'b0;
    drain(20);
    check("err_set_wins", {31'h0, bus.ERR}, 32'h1);
    check("ovr_not_set",  {31'h0, bus.OVR}, 32'h0);
    clear_flags();

    // Overlap: extra requests in DEC and DONE are dropped, the next IDLE one is taken.
    step();
    drive_req(1'b1, 14'h3FE1, 16'h1111);
    push(3, 16'hC000, 16'h1111, 1'b0, 8'h02);
    step();
    drive_req(1'b1, 14'h3FE2, 16'h2222);
    step();
    bus.REQ = 1'b0;
    step();
    drive_req(1'b1, 14'h3FE6, 16'h6666);
    step();
    drive_req(1'b0, 14'h3FE5, 16'h0000);
    push(3, 16'h1234, 16'h1111, 1'b0, 8'h00);
    step();
    bus.REQ = 1'b0;
    drain(20);
    check("ovr_set",   {31'h0, bus.OVR}, 32'h1);
    check("ovr_noerr", {31'h0, bus.ERR}, 32'h0);
    clear_flags();
    check("ovr_clr",   {31'h0, bus.OVR}, 32'h0);

    // Reset during the WR cycle of a write.
    step();
    drive_req(1'b1, 14'h3FE4, 16'hCAFE);
    step();
    bus.REQ = 1'b0;
    step();
    RST = 1'b1;
    @(negedge CK);
    check("mid_wr_pulse", {24'h0, WBen}, 32'h10);
    step();
    RST = 1'b0;
    @(negedge CK);
    check("abort_wben", {24'h0, WBen}, 32'h00);
    check("abort_gnt",  {31'h0, bus.GNT}, 32'h0);
    check("abort_busy", {31'h0, bus.BUSY}, 32'h0);
    check("abort_di",   {16'h0, DI}, 32'h0);
    repeat (4) step();
    access(1'b0, 14'h3FE5, 16'h0000, 3, 16'h1234, 16'h0000, 1'b0, 8'h00);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
